// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the weight-stationary systolic array.
package systolic_pkg;

    localparam int unsigned N_DEF  = 3;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned AW_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOADED,
        STREAM,
        DRAIN
    } state_t;

    // Handshake/status flags held in registers alongside the state
    typedef struct packed {
        logic w_open;
        logic in_rdy;
        logic busy;
    } ctl_t;

    // Flags that hold while the FSM sits in a given state
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            IDLE:    begin c.w_open = 1'b1; c.in_rdy = 1'b0; c.busy = 1'b0; end
            LOAD_W:  begin c.w_open = 1'b1; c.in_rdy = 1'b0; c.busy = 1'b1; end
            LOADED:  begin c.w_open = 1'b1; c.in_rdy = 1'b1; c.busy = 1'b0; end
            STREAM:  begin c.w_open = 1'b0; c.in_rdy = 1'b1; c.busy = 1'b1; end
            DRAIN:   begin c.w_open = 1'b0; c.in_rdy = 1'b0; c.busy = 1'b1; end
            default: begin c.w_open = 1'b1; c.in_rdy = 1'b0; c.busy = 1'b0; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element: stationary weight, eastbound activation, southbound psum.
module mac_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_load,
    input  logic signed [DW-1:0] w_in,
    input  logic signed [DW-1:0] act_in,
    input  logic signed [AW-1:0] psum_in,
    output logic signed [DW-1:0] act_out,
    output logic signed [AW-1:0] psum_out
);

    logic signed [DW-1:0]   weight;
    logic signed [2*DW-1:0] prod_c;

    // Full-width signed product; sign-extended into the accumulator below
    assign prod_c = act_in * weight;

    // Weight holds until reloaded; activation and psum advance every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            weight   <= '0;
            act_out  <= '0;
            psum_out <= '0;
        end else begin
            if (w_load) begin
                weight <= w_in;
            end
            act_out  <= act_in;
            psum_out <= psum_in + AW'(prod_c);
        end
    end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N weight-stationary systolic array computing y = x * W with fixed 2N latency.
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_valid,
    input  logic [N*DW-1:0] w_data,
    output logic            w_ready,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    output logic [N*AW-1:0] out_data,
    output logic            busy
);

    localparam int unsigned WROW_W = $clog2(N);
    localparam int unsigned LAT    = 2 * N;

    state_t              state;
    state_t              state_nxt_c;
    ctl_t                ctl;
    logic [WROW_W-1:0]   wrow;
    logic [LAT-2:0]      vtag;
    logic                w_fire_c;
    logic                in_fire_c;
    logic                drain_done_c;
    logic [N-1:0]        row_load_c;
    logic [N*AW-1:0]     out_nxt_c;

    logic signed [DW-1:0] lane_in [N];
    logic signed [DW-1:0] act_o   [N][N];
    logic signed [AW-1:0] psum_o  [N][N];
    logic signed [AW-1:0] col_out [N];

    // Activations take priority over a simultaneous weight beat in LOADED
    assign w_ready      = ctl.w_open & ~(ctl.in_rdy & in_valid);
    assign in_ready     = ctl.in_rdy;
    assign busy         = ctl.busy;
    assign w_fire_c     = w_valid & w_ready;
    assign in_fire_c    = in_valid & ctl.in_rdy;
    assign drain_done_c = out_valid & (vtag == '0);

    // Next-state decode
    always_comb begin
        state_nxt_c = state;
        case (state)
            IDLE: begin
                if (w_fire_c) state_nxt_c = LOAD_W;
            end
            LOAD_W: begin
                if (w_fire_c && (wrow == WROW_W'(N - 1))) state_nxt_c = LOADED;
            end
            LOADED: begin
                if (in_fire_c)     state_nxt_c = in_last ? DRAIN : STREAM;
                else if (w_fire_c) state_nxt_c = LOAD_W;
            end
            STREAM: begin
                if (in_fire_c && in_last) state_nxt_c = DRAIN;
            end
            DRAIN: begin
                if (drain_done_c) state_nxt_c = LOADED;
            end
            default: state_nxt_c = IDLE;
        endcase
    end

    // State, registered handshake flags and weight row pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ctl   <= ctl_of(IDLE);
            wrow  <= '0;
        end else begin
            state <= state_nxt_c;
            ctl   <= ctl_of(state_nxt_c);
            if (w_fire_c) begin
                wrow <= (wrow == WROW_W'(N - 1)) ? '0 : wrow + WROW_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        logic signed [DW-1:0] x_c;
        logic                 unused_east;

        // Idle cycles inject zeros so bubbles carry no stale data
        assign x_c            = in_fire_c ? in_data[i*DW +: DW] : '0;
        assign row_load_c[i]  = w_fire_c & (wrow == WROW_W'(i));
        assign unused_east    = ^act_o[i][N-1];

        if (i == 0) begin : g_noskew
            assign lane_in[i] = x_c;
        end else begin : g_skew
            logic signed [DW-1:0] sk [i];

            // Lane i is delayed i cycles so it meets the row-(i-1) psum
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) sk[k] <= '0;
                end else begin
                    sk[0] <= x_c;
                    for (int k = 1; k < i; k++) sk[k] <= sk[k-1];
                end
            end

            assign lane_in[i] = sk[i-1];
        end

        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] act_in_c;
            logic signed [AW-1:0] psum_in_c;

            if (j == 0) begin : g_west
                assign act_in_c = lane_in[i];
            end else begin : g_inner_a
                assign act_in_c = act_o[i][j-1];
            end

            if (i == 0) begin : g_north
                assign psum_in_c = '0;
            end else begin : g_inner_p
                assign psum_in_c = psum_o[i-1][j];
            end

            mac_pe #(
                .DW (DW),
                .AW (AW)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .w_load   (row_load_c[i]),
                .w_in     (w_data[j*DW +: DW]),
                .act_in   (act_in_c),
                .psum_in  (psum_in_c),
                .act_out  (act_o[i][j]),
                .psum_out (psum_o[i][j])
            );
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_deskew
        if (j == N - 1) begin : g_direct
            assign col_out[j] = psum_o[N-1][j];
        end else begin : g_delay
            localparam int unsigned D = N - 1 - j;
            logic signed [AW-1:0] dk [D];

            // Column j finishes N-1-j cycles early; hold it back to align lanes
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < int'(D); k++) dk[k] <= '0;
                end else begin
                    dk[0] <= psum_o[N-1][j];
                    for (int k = 1; k < int'(D); k++) dk[k] <= dk[k-1];
                end
            end

            assign col_out[j] = dk[D-1];
        end

        assign out_nxt_c[j*AW +: AW] = col_out[j];
    end

    // Valid tags ride alongside the data; result captured only when tagged
    always_ff @(posedge clk) begin
        if (rst) begin
            vtag      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            vtag      <= {vtag[LAT-3:0], in_fire_c};
            out_valid <= vtag[LAT-2];
            if (vtag[LAT-2]) begin
                out_data <= out_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomized bench for systolic_array_nxn with a matrix-product reference model.
module tb_systolic_array_nxn;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int LAT = 2 * N;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            w_valid = 1'b0;
    logic [N*DW-1:0] w_data = '0;
    logic            w_ready;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic            in_last = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic [N*AW-1:0] out_data;
    logic            busy;

    systolic_array_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, {32'b0, act}, {32'b0, exp});
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int              due;
        logic [N*AW-1:0] y;
    } exp_t;

    int              w_m [N][N];
    int              wrow_m = 0;
    exp_t            exp_q [$];
    logic [N*AW-1:0] last_out = '0;
    logic [N*AW-1:0] hist [$];
    int              hist_cyc [$];

    function automatic logic [N*AW-1:0] model_y(input logic [N*DW-1:0] x);
        logic [N*AW-1:0] y;
        longint          s;
        y = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += longint'($signed(x[i*DW +: DW])) * longint'(w_m[i][j]);
            y[j*AW +: AW] = 32'(s);
        end
        return y;
    endfunction

    // Per-cycle comparison of DUT outputs against the model
    initial begin
        forever begin
            bit ev;
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                wrow_m   = 0;
                last_out = '0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) w_m[i][j] = 0;
            end else begin
                ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                chk("out_valid", 64'(out_valid), 64'(ev));
                if (ev) begin
                    for (int j = 0; j < N; j++)
                        chk32("y_lane", out_data[j*AW +: AW], exp_q[0].y[j*AW +: AW]);
                    last_out = exp_q[0].y;
                    void'(exp_q.pop_front());
                end else begin
                    for (int j = 0; j < N; j++)
                        chk32("out_hold", out_data[j*AW +: AW], last_out[j*AW +: AW]);
                end
                if (out_valid === 1'b1) begin
                    hist.push_back(out_data);
                    hist_cyc.push_back(cyc);
                end
                if (in_valid && in_ready) begin
                    exp_t e;
                    e.due = cyc + LAT;
                    e.y   = model_y(in_data);
                    exp_q.push_back(e);
                end
                if (w_valid && w_ready) begin
                    for (int j = 0; j < N; j++) w_m[wrow_m][j] = int'($signed(w_data[j*DW +: DW]));
                    wrow_m = (wrow_m + 1) % N;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] vec3(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [N*N*DW-1:0] fill(input int v);
        logic [N*N*DW-1:0] m;
        for (int k = 0; k < N * N; k++) m[k*DW +: DW] = 16'(v);
        return m;
    endfunction

    function automatic logic [N*N*DW-1:0] ident();
        logic [N*N*DW-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) m[(k*N + k)*DW +: DW] = 16'd1;
        return m;
    endfunction

    function automatic logic [DW-1:0] rand_dw();
        case ($urandom_range(5, 0))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic load_w(input logic [N*N*DW-1:0] m);
        for (int k = 0; k < N; k++) begin
            w_valid = 1'b1;
            w_data  = m[k*N*DW +: N*DW];
            tick();
            if (k == 0) chk("busy_loading", 64'(busy), 64'd1);
        end
        w_valid = 1'b0;
    endtask

    task automatic send(input logic [N*DW-1:0] x, input logic last);
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_loaded(input string name);
        int n;
        n = 0;
        while (!(in_ready === 1'b1 && busy === 1'b0) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n < 60), 64'd1);
    endtask

    task automatic chk_hist(input string name, input int idx, input int a, input int b, input int c);
        logic [N*AW-1:0] h;
        chk({name, "_count"}, 64'(hist.size() > idx), 64'd1);
        if (hist.size() > idx) begin
            h = hist[idx];
            chk32({name, "_y0"}, h[0*AW +: AW], 32'(a));
            chk32({name, "_y1"}, h[1*AW +: AW], 32'(b));
            chk32({name, "_y2"}, h[2*AW +: AW], 32'(c));
        end
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        int acc;
        logic [N*N*DW-1:0] m;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_w_ready",   64'(w_ready),   64'd1);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);

        // Identity weights: y = x, six cycles after acceptance
        load_w(ident());
        chk("loaded_in_ready", 64'(in_ready), 64'd1);
        chk("loaded_busy",     64'(busy),     64'd0);
        hist.delete(); hist_cyc.delete();
        acc = cyc;
        send(vec3(5, -7, 9), 1'b1);
        wait_loaded("ident");
        chk_hist("ident", 0, 5, -7, 9);
        if (hist_cyc.size() > 0) chk("ident_latency", 64'(hist_cyc[0] - acc), 64'd6);

        // All-2 weights, four back-to-back vectors
        load_w(fill(2));
        hist.delete(); hist_cyc.delete();
        acc = cyc;
        send(vec3(1, 2, 3), 1'b0);
        send(vec3(0, 0, 1), 1'b0);
        send(vec3(-1, -1, -1), 1'b0);
        send(vec3(4, 0, 0), 1'b1);
        wait_loaded("burst");
        chk_hist("burst0", 0, 12, 12, 12);
        chk_hist("burst1", 1, 2, 2, 2);
        chk_hist("burst2", 2, -6, -6, -6);
        chk_hist("burst3", 3, 8, 8, 8);
        if (hist_cyc.size() == 4) begin
            chk("burst_latency", 64'(hist_cyc[0] - acc), 64'd6);
            chk("burst_back2back", 64'(hist_cyc[3] - hist_cyc[0]), 64'd3);
        end

        // Largest positive operands: wraps past 2^31
        load_w(fill(32'h7FFF));
        hist.delete(); hist_cyc.delete();
        send(vec3(32'h7FFF, 32'h7FFF, 32'h7FFF), 1'b1);
        wait_loaded("maxpos");
        chk_hist("maxpos", 0, 32'hBFFD0003, 32'hBFFD0003, 32'hBFFD0003);

        // Simultaneous weight beat and vector in LOADED: vector wins
        load_w(fill(2));
        hist.delete(); hist_cyc.delete();
        w_valid = 1'b1; w_data = vec3(100, 100, 100);
        in_valid = 1'b1; in_data = vec3(1, 2, 3); in_last = 1'b1;
        #1;
        chk("collide_w_ready", 64'(w_ready), 64'd0);
        tick();
        w_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("collide_drain_busy",     64'(busy),     64'd1);
        chk("collide_drain_in_ready", 64'(in_ready), 64'd0);
        chk("collide_drain_w_ready",  64'(w_ready),  64'd0);
        wait_loaded("collide");
        chk("collide_in_ready", 64'(in_ready), 64'd1);
        send(vec3(1, 1, 1), 1'b1);
        wait_loaded("collide2");
        chk_hist("collide", 0, 12, 12, 12);
        chk_hist("retained", 1, 6, 6, 6);

        // Randomized batches with gaps and blocked weight noise
        for (int r = 0; r < 8; r++) begin
            int nv;
            if (r == 0 || $urandom_range(1, 0) == 1) begin
                for (int k = 0; k < N * N; k++) m[k*DW +: DW] = rand_dw();
                load_w(m);
            end
            nv = $urandom_range(10, 1);
            for (int v = 0; v < nv; v++) begin
                int ng;
                ng = (v > 0) ? $urandom_range(2, 0) : 0;
                for (int g = 0; g < ng; g++) begin
                    in_valid = 1'b0;
                    w_valid  = 1'($urandom_range(1, 0));
                    w_data   = {rand_dw(), rand_dw(), rand_dw()};
                    tick();
                end
                in_valid = 1'b1;
                in_data  = {rand_dw(), rand_dw(), rand_dw()};
                in_last  = (v == nv - 1);
                w_valid  = (v > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
                w_data   = {rand_dw(), rand_dw(), rand_dw()};
                tick();
            end
            in_valid = 1'b0; in_last = 1'b0; w_valid = 1'b0;
            wait_loaded("random");
        end

        // Reset while three vectors are in flight
        load_w(fill(3));
        hist.delete(); hist_cyc.delete();
        send(vec3(1, 1, 1), 1'b0);
        send(vec3(2, 2, 2), 1'b0);
        send(vec3(3, 3, 3), 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_w_ready",   64'(w_ready),   64'd1);
        chk("midrst_in_ready",  64'(in_ready),  64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (20) tick();
        chk("midrst_no_output", 64'(hist.size()), 64'd0);

        // Recovery after reset
        load_w(ident());
        hist.delete(); hist_cyc.delete();
        send(vec3(-3, 4, 32'h8000), 1'b1);
        wait_loaded("recover");
        chk_hist("recover", 0, -3, 4, -32768);

        repeat (4) tick();
        chk("pending_results", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/systolic_array_nxn.md
SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001 Parameter N, default 3: array dimension (N x N PEs), N >= 2.
REQ-002 Parameter DW, default 16: activation and weight width, signed two's complement.
REQ-003 Parameter AW, default 32: accumulator and output width, signed, AW >= 2*DW.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 w_valid  in  1  weight row beat offered.
REQ-007 w_data  in  N*DW  weight row; lane j (bits j*DW+:DW) is W[k][j] for beat k.
REQ-008 w_ready  out  1  weight beat accepted when w_valid and w_ready are both high.
REQ-009 in_valid  in  1  activation vector offered.
REQ-010 in_data  in  N*DW  activation vector x; lane i feeds PE row i.
REQ-011 in_last  in  1  marks final vector of a batch; qualified by in_valid.
REQ-012 in_ready  out  1  vector accepted when in_valid and in_ready are both high.
REQ-013 out_valid  out  1  result vector present; no backpressure.
REQ-014 out_data  out  N*AW  result y; lane j = sum over i of x[i]*W[i][j].
REQ-015 busy  out  1  high in LOAD_W, STREAM and DRAIN.

Function
REQ-016 FSM states: IDLE, LOAD_W, LOADED, STREAM, DRAIN.
REQ-017 IDLE: w_ready=1, in_ready=0; an accepted beat stores row 0 and moves to LOAD_W.
REQ-018 LOAD_W: w_ready=1, in_ready=0; beat k stores PE row k; acceptance of beat N-1 moves to LOADED.
REQ-019 LOADED: in_ready=1; w_ready = !in_valid, so activations win over simultaneous weights; an accepted weight beat restarts loading at row 0 (LOAD_W); an accepted vector enters STREAM (or DRAIN if in_last).
REQ-020 STREAM: in_ready=1, w_ready=0; one vector accepted per cycle maximum; in_valid gaps are allowed and produce no output.
REQ-021 An accepted vector with in_last moves to DRAIN; in DRAIN in_ready=0 and w_ready=0.
REQ-022 DRAIN returns to LOADED in the cycle after the last in-flight out_valid; weights are retained.
REQ-023 Dataflow is weight-stationary: activations move east one PE per cycle, partial sums move south one PE per cycle, and row-0 psum input is 0.
REQ-024 Input skew: lane i is delayed i cycles before entering row i. Output deskew: column j is delayed N-1-j cycles, so all lanes of one y emerge in the same cycle.
REQ-025 Latency is fixed: a vector accepted at cycle t yields out_valid at cycle t+2N (6 for N=3), regardless of gaps.
REQ-026 A valid tag travels with each vector; out_valid is high exactly once per accepted vector, in acceptance order.
REQ-027 Products are full 2*DW signed, sign-extended to AW; sums wrap modulo 2^AW with no saturation.
REQ-028 When out_valid=0, out_data holds its last value.
REQ-029 Weights never change while any vector is in flight.

Reset
REQ-030 With rst high at a clock edge: state=IDLE; all weight, activation, psum, skew and deskew registers = 0; all valid tags = 0.
REQ-031 Outputs after reset: w_ready=1, in_ready=0, out_valid=0, out_data=0, busy=0.
REQ-032 Reset mid-operation discards all in-flight vectors and loaded weights; no out_valid appears until new vectors are accepted.

Structure
REQ-033 Shared package systolic_pkg holds the FSM state enum and the default values of N, DW and AW.
REQ-034 Sub-module mac_pe holds one PE: weight register with load enable, activation register, and psum register computing psum_in + act*weight. It is instantiated N*N times via generate.
REQ-035 The skew, deskew, valid-tag pipeline and FSM reside in systolic_array_nxn.

Verification
REQ-036 N=3, W=identity, x=[5,-7,9] accepted at t -> out_valid at t+6 with y=[5,-7,9].
REQ-037 W all 2, four vectors on consecutive cycles x=[1,2,3],[0,0,1],[-1,-1,-1],[4,0,0] -> y=[12,12,12],[2,2,2],[-6,-6,-6],[8,8,8] on four consecutive cycles from t+6.
REQ-038 W all 0x7FFF, x=[0x7FFF,0x7FFF,0x7FFF], AW=32 -> every y lane = 3221028867 mod 2^32 (-1073938429 signed).
REQ-039 In LOADED, assert w_valid and in_valid in the same cycle -> vector accepted, w_ready=0, weights unchanged; in_last batch -> DRAIN, then LOADED with in_ready=1.
REQ-040 Pulse rst two cycles after accepting three vectors -> no out_valid afterward, w_ready=1, in_ready=0, busy=0.
